// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and helpers for the async FIFO.
//   wr_state_e  - skid buffer occupancy state (EMPTY/ONE/TWO)
//   STALL_CNT_W - width of the write-side stall counter
//   gray2bin    - Gray-to-binary conversion, usable for any pointer width
//                 up to GRAY_MAX_W (zero-extend the input, slice the result)
package fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } wr_state_e;

  localparam int STALL_CNT_W = 16;
  localparam int GRAY_MAX_W  = 32;

  // Each binary bit is the XOR of all Gray bits at and above it. Zero
  // upper bits leave the result unchanged, so narrower pointers can share
  // this one function.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b = '0;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry skid buffer between the producer stream and the
// FIFO write port. Outputs are driven from flops only, so neither w_full
// nor s_valid has a combinational path to s_ready, w_en or w_data.
// Ports:
//   clk, rst_n        - clock, async active-low reset
//   s_valid/s_data    - producer stream in
//   s_ready           - buffer can take a word (low in TWO and until the
//                       first edge after reset release)
//   w_full            - FIFO full from the write-pointer/full stage
//   w_en/w_data       - write request and head-of-buffer data
//   pop               - a word leaves the buffer this cycle
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATASIZE = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  input  logic [DATASIZE-1:0] s_data,
  output logic                s_ready,
  input  logic                w_full,
  output logic                w_en,
  output logic [DATASIZE-1:0] w_data,
  output logic                pop
);

  wr_state_e             state_q, state_d;
  logic [DATASIZE-1:0]   head_q, head_d;
  logic [DATASIZE-1:0]   tail_q, tail_d;
  logic                  rst_done_q, rst_done_d;
  logic                  push;

  assign s_ready = rst_done_q && (state_q != TWO);
  assign w_en    = (state_q != EMPTY);
  assign w_data  = head_q;
  assign push    = s_valid && s_ready;
  assign pop     = w_en && !w_full;

  // Holds s_ready low for one edge after reset release.
  assign rst_done_d = 1'b1;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = s_data;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = s_data;
        end else if (push) begin
          tail_d  = s_data;
          state_d = TWO;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        // No push possible here: s_ready is low.
        if (pop) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      rst_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      rst_done_q <= rst_done_d;
    end
  end

endmodule

// File: rtl/fifo_wr_frontend.sv
// fifo_wr_frontend: write-domain front end of the async FIFO.
// Accepts the producer stream into a 2-entry skid buffer, drives the FIFO
// write port, and derives a registered occupancy and almost-full flag from
// its own binary write count and the synchronized Gray read pointer.
// Optional feature macro: FIFO_WR_STATS_EN enables the saturating stall
// counter; otherwise w_stall_cnt is tied to 0.
// Ports:
//   w_clk, w_rst_n  - write clock, async active-low reset
//   s_valid/s_data  - producer stream in; s_ready back to producer
//   w_full          - FIFO full from the write-pointer/full stage
//   wq2_rptr        - Gray read pointer, already synchronized to w_clk
//   w_en/w_data     - write request/data; a write happens on w_en && !w_full
//   w_level         - registered occupancy 0..2^ADDRSIZE
//   w_afull         - registered occupancy >= AFULL_THRESH
//   w_stall_cnt     - cycles with w_en && w_full, saturating
module fifo_wr_frontend
  import fifo_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int ADDRSIZE     = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                   w_clk,
  input  logic                   w_rst_n,
  input  logic                   s_valid,
  input  logic [DATASIZE-1:0]    s_data,
  output logic                   s_ready,
  input  logic                   w_full,
  input  logic [ADDRSIZE:0]      wq2_rptr,
  output logic                   w_en,
  output logic [DATASIZE-1:0]    w_data,
  output logic [ADDRSIZE:0]      w_level,
  output logic                   w_afull,
  output logic [STALL_CNT_W-1:0] w_stall_cnt
);

  localparam int PW = ADDRSIZE + 1;

  logic                  pop;
  logic [PW-1:0]         wcount_q, wcount_d;
  logic [PW-1:0]         level_q, level_next;
  logic                  afull_q, afull_d;
  logic [GRAY_MAX_W-1:0] rptr_bin_full;
  logic [PW-1:0]         rptr_bin;

  fifo_skid_buf #(
    .DATASIZE (DATASIZE)
  ) u_skid (
    .clk     (w_clk),
    .rst_n   (w_rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .w_full  (w_full),
    .w_en    (w_en),
    .w_data  (w_data),
    .pop     (pop)
  );

  // Level uses the registered count, so a pop shows in w_level one edge
  // after it shows in wcount. Subtraction wraps mod 2^PW like the pointers.
  always_comb begin
    rptr_bin_full = gray2bin(GRAY_MAX_W'(wq2_rptr));
    rptr_bin      = rptr_bin_full[PW-1:0];
    wcount_d      = wcount_q + PW'(pop);
    level_next    = wcount_q - rptr_bin;
    afull_d       = (int'(level_next) >= AFULL_THRESH);
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      wcount_q <= '0;
      level_q  <= '0;
      afull_q  <= 1'b0;
    end else begin
      wcount_q <= wcount_d;
      level_q  <= level_next;
      afull_q  <= afull_d;
    end
  end

  assign w_level = level_q;
  assign w_afull = afull_q;

`ifdef FIFO_WR_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (w_en && w_full && (stall_q != {STALL_CNT_W{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign w_stall_cnt = stall_q;
`else
  assign w_stall_cnt = '0;
`endif

endmodule
